// File: rtl/mem_addr_sequencer.sv
// Memory address source select with a fixed-latency IDLE/WAIT/DONE access sequencer.
// Optional misaligned-access rejection is enabled with `define MEM_ADDR_ALIGN_CHECK_EN.
module mem_addr_sequencer #(
  parameter int DATA_W  = 32,
  parameter int N_SRC   = 5,
  parameter int SEL_W   = 3,
  parameter int MEM_LAT = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_SRC*DATA_W-1:0]   src_flat,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      req,
  input  logic                      wr,
  input  logic [1:0]                size,
  output logic [DATA_W-1:0]         addr,
  output logic                      mem_wr,
  output logic                      busy,
  output logic                      done,
  output logic                      sel_err,
  output logic                      misalign
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              wr_lat;
  logic              capture;
  logic [DATA_W-1:0] sel_addr;
  logic              sel_oob;
  logic              cap_mis;

  // Out-of-range selects fall back to source 0 and raise sel_err at capture.
  always_comb begin
    sel_addr = src_flat[0 +: DATA_W];
    sel_oob  = 1'b1;
    for (int i = 0; i < N_SRC; i++) begin
      if (sel == SEL_W'(i)) begin
        sel_addr = src_flat[i*DATA_W +: DATA_W];
        sel_oob  = 1'b0;
      end
    end
  end

`ifdef MEM_ADDR_ALIGN_CHECK_EN
  always_comb begin
    cap_mis = 1'b0;
    case (size)
      2'b00:   cap_mis = |sel_addr[1:0];
      2'b01:   cap_mis = sel_addr[0];
      default: cap_mis = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      misalign <= 1'b0;
    end else if (capture) begin
      misalign <= cap_mis;
    end
  end
`else
  logic unused_size;

  assign cap_mis     = 1'b0;
  assign misalign    = 1'b0;
  assign unused_size = ^size;
`endif

  assign capture = req && ((state == ST_IDLE) || (state == ST_DONE));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A rejected (misaligned) access skips WAIT and reports straight away.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (req) begin
          state_nxt = cap_mis ? ST_DONE : ST_WAIT;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt == '0) begin
          state_nxt = ST_DONE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr    <= '0;
      sel_err <= 1'b0;
      wr_lat  <= 1'b0;
      cnt     <= '0;
    end else if (capture) begin
      addr    <= sel_addr;
      sel_err <= sel_oob;
      wr_lat  <= wr;
      cnt     <= CNT_LOAD;
    end else if ((state == ST_WAIT) && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign busy   = (state == ST_WAIT);
  assign done   = (state == ST_DONE);
  assign mem_wr = (state == ST_WAIT) && wr_lat;

endmodule

// File: doc/mem_addr_sequencer.md
Name: mem_addr_sequencer

Overview:
Parametrised successor to the fixed 5-way memory-address source mux in the multicycle datapath. Selects one of N_SRC address sources and registers it at request time. Runs a fixed-latency memory access sequence (IDLE/WAIT/DONE) with a done pulse, and flags out-of-range selects. Sits between the datapath address sources (PC, exception vector, ALU result, ALUOut, A) and the memory port, and is driven by the control FSM.

Parameters:
DATA_W, 32, width of each address source and of addr
N_SRC, 5, number of address sources (2..2**SEL_W)
SEL_W, 3, width of sel
MEM_LAT, 1, memory wait cycles per access (>=1)

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
src_flat  in  N_SRC*DATA_W  concatenated sources; source i = src_flat[i*DATA_W +: DATA_W]
sel  in  SEL_W  source select (IorD)
req  in  1  start access; sampled on rising edge
wr  in  1  access is a write; captured with req
size  in  2  00 word, 01 half, 10 byte, 11 treated as byte
addr  out  DATA_W  registered selected address
mem_wr  out  1  memory write strobe
busy  out  1  access in progress
done  out  1  one-cycle completion pulse
sel_err  out  1  last captured sel was >= N_SRC
misalign  out  1  last access was rejected as misaligned (feature only)

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset, applied at any time including mid-access: state=IDLE, counter=0, addr=0, mem_wr=0, busy=0, done=0, sel_err=0, misalign=0. An in-flight access is abandoned without a done pulse.
- Capture: a req seen in IDLE or DONE at a rising edge:
  - addr <= src[sel]; if sel >= N_SRC, addr <= src[0] and sel_err <= 1, otherwise sel_err <= 0.
  - wr is latched; counter <= MEM_LAT-1; next state WAIT.
- IDLE: busy=0, mem_wr=0, done=0. addr holds its last value. No req -> stay in IDLE.
- WAIT:
  - busy=1; mem_wr = latched wr.
  - The counter decrements each edge; on the edge where the counter==0 -> DONE.
  - req is ignored (no queueing).
  - sel and src changes do not affect addr.
  - Duration is exactly MEM_LAT cycles.
- DONE: done=1 and busy=0 for one cycle; mem_wr=0. req -> capture and go to WAIT (back-to-back access); otherwise -> IDLE.
- Latency, MEM_LAT=1: req high at edge 0 -> addr valid after edge 0, WAIT for cycle 1, done high in cycle 2.
- All outputs are registered or decoded from the state register. There is no combinational path from sel or src to addr.

Optional Feature:
- Macro: MEM_ADDR_ALIGN_CHECK_EN.
- Defined:
  - At capture, the selected address is checked: word requires addr[1:0]==0; half requires addr[0]==0; byte is always aligned.
  - Misaligned: addr is still captured, the FSM goes directly to DONE (skipping WAIT), mem_wr is never asserted, and misalign <= 1 alongside done.
  - misalign clears at the next capture or on reset.
- Undefined: size is ignored, misalign is tied to 0, and every access runs WAIT.

Test Plan:
- Reset mid-WAIT: MEM_LAT=4, wr=1, assert reset in the 2nd WAIT cycle -> addr=0, mem_wr=0, busy=0 immediately (asynchronous), and no done pulse follows.
- Source select: src0..4 = 0x100, 0x80000180, 0x2000, 0x3004, 0x4008; sel=3, req 1 cycle, MEM_LAT=1 -> addr=0x3004 after the capture edge, busy for 1 cycle, done in the following cycle, sel_err=0.
- Out-of-range select: sel=7, N_SRC=5 -> addr=0x100, sel_err=1. Next access with sel=2 -> addr=0x2000, sel_err=0.
- Back-to-back: req held high, MEM_LAT=2 -> done pulses every 3 cycles. Changes on sel/src during WAIT do not change addr. A write access has mem_wr high for exactly 2 cycles per access.
- Alignment (macro defined): size=word, address 0x3006 -> done one cycle after capture, misalign=1, mem_wr never high. Same stimulus with size=half -> normal access, misalign=0.
- Alignment (macro undefined): size=word, address 0x3006 -> normal MEM_LAT access, misalign=0.
